// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential FP multiplier (fp_mul_seq).
// Optional feature macro used by this block: FPMUL_RNE_EN (selected in fp_mul_round).
package fp_mul_pkg;

    typedef enum logic [2:0] {IDLE, MULT, NORM, RND, DONE} fp_state_e;

    typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} fp_cls_e;

    // Flag vector layout: {invalid, overflow, underflow, inexact}
    localparam int FLG_W   = 4;
    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    // Operand fields are sized for the widest supported format; users cast down.
    localparam int OP_EXP_MAXW = 16;
    localparam int OP_SIG_MAXW = 64;

    typedef struct packed {
        logic                   sign;
        logic [OP_EXP_MAXW-1:0] exp;
        logic [OP_SIG_MAXW-1:0] sig;
        fp_cls_e                cls;
    } fp_op_t;

    function automatic int bias_f(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int exp_max_f(input int ew);
        return (1 << ew) - 1;
    endfunction

    function automatic logic [63:0] qnan_f(input int ew, input int mw);
        logic [63:0] v;
        v = ((64'd1 << ew) - 64'd1) << mw;
        v = v | (64'd1 << (mw - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand-issue / result handshake bundle for fp_mul_seq.
// Optional feature macro of this block: FPMUL_RNE_EN (no effect on this interface).
interface fp_mul_seq_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_mul_round.sv
// Rounding, carry renormalise, overflow/underflow clamp and pack for fp_mul_seq.
// FPMUL_RNE_EN defined: round-to-nearest-even; undefined: truncate, overflow saturates to max finite.
module fp_mul_round
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                      sign_i,
    input  logic signed [EXP_W+1:0]   exp_i,
    input  logic [MAN_W-1:0]          frac_i,
    input  logic                      guard_i,
    input  logic                      sticky_i,
    output logic [EXP_W+MAN_W:0]      result_o,
    output logic                      ovf_o,
    output logic                      unf_o,
    output logic                      inx_o
);
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EMAX = EW'(exp_max_f(EXP_W));
`ifndef FPMUL_RNE_EN
    localparam logic [EXP_W-1:0] EXP_MAXFIN = EXP_W'(exp_max_f(EXP_W) - 1);
`endif

    logic                 inc;
    logic [MAN_W:0]       frac_sum;
    logic signed [EW-1:0] exp_r;
    logic                 ovf;
    logic                 unf;

    always_comb begin
`ifdef FPMUL_RNE_EN
        inc = guard_i & (sticky_i | frac_i[0]);
`else
        inc = 1'b0;
`endif
        // An all-ones fraction that rounds up wraps to zero; the carry bumps the exponent.
        frac_sum = {1'b0, frac_i} + (MAN_W+1)'(inc);
        exp_r    = exp_i + EW'(frac_sum[MAN_W]);
        ovf      = !exp_r[EW-1] && (exp_r >= EMAX);
        unf      = exp_r[EW-1] || (exp_r == '0);

        ovf_o    = 1'b0;
        unf_o    = 1'b0;
        inx_o    = guard_i | sticky_i;
        result_o = {sign_i, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
        if (ovf) begin
            ovf_o = 1'b1;
            inx_o = 1'b1;
`ifdef FPMUL_RNE_EN
            result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
            result_o = {sign_i, EXP_MAXFIN, {MAN_W{1'b1}}};
`endif
        end else if (unf) begin
            unf_o    = 1'b1;
            inx_o    = 1'b1;
            result_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential shift-add floating-point multiplier with valid/ready on both sides.
// Rounding mode chosen by macro FPMUL_RNE_EN (see fp_mul_round).
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    fp_mul_seq_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(M + 1);
    localparam logic [EW-1:0] BIAS_E  = EW'(bias_f(EXP_W));
    localparam logic [CW-1:0] LAST_IT = CW'(M - 1);
    localparam logic [63:0]   QNAN64  = qnan_f(EXP_W, MAN_W);

    function automatic fp_op_t unpack(input logic [W-1:0] x);
        fp_op_t           u;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e      = x[W-2:MAN_W];
        f      = x[MAN_W-1:0];
        u.sign = x[W-1];
        u.exp  = OP_EXP_MAXW'(e);
        u.sig  = OP_SIG_MAXW'({1'b1, f});
        // Subnormals flush to zero.
        if (e == '0)     u.cls = CL_ZERO;
        else if (&e)     u.cls = (|f) ? CL_NAN : CL_INF;
        else             u.cls = CL_NORM;
        return u;
    endfunction

    fp_state_e            state_q, state_d;
    logic                 sign_q, sign_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic [M-1:0]         mc_q, mc_d;
    logic [M-1:0]         mp_q, mp_d;
    logic [2*M-1:0]       acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 stk_q, stk_d;
    logic [W-1:0]         result_q, result_d;
    logic [FLG_W-1:0]     flags_q, flags_d;

    fp_op_t       op_a, op_b;
    logic         sp_any, sp_nan;
    logic [W-1:0] sp_result;
    logic [M:0]   mac_sum;
    logic [W-1:0] rnd_result;
    logic         rnd_ovf, rnd_unf, rnd_inx;

    always_comb begin
        op_a   = unpack(bus.a);
        op_b   = unpack(bus.b);
        sp_any = (op_a.cls != CL_NORM) || (op_b.cls != CL_NORM);
        sp_nan = (op_a.cls == CL_NAN) || (op_b.cls == CL_NAN) ||
                 (op_a.cls == CL_INF && op_b.cls == CL_ZERO) ||
                 (op_a.cls == CL_ZERO && op_b.cls == CL_INF);
        if (sp_nan)
            sp_result = QNAN64[W-1:0];
        else if (op_a.cls == CL_INF || op_b.cls == CL_INF)
            sp_result = {op_a.sign ^ op_b.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            sp_result = {op_a.sign ^ op_b.sign, {(W-1){1'b0}}};
    end

    fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .frac_i   (acc_q[2*M-3:M-1]),
        .guard_i  (acc_q[M-2]),
        .sticky_i (stk_q | (|acc_q[M-3:0])),
        .result_o (rnd_result),
        .ovf_o    (rnd_ovf),
        .unf_o    (rnd_unf),
        .inx_o    (rnd_inx)
    );

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mc_d     = mc_q;
        mp_d     = mp_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        stk_d    = stk_q;
        result_d = result_q;
        flags_d  = flags_q;
        // Upper half plus multiplicand; the carry becomes the new MSB after the shift.
        mac_sum  = {1'b0, acc_q[2*M-1:M]} + (mp_q[0] ? {1'b0, mc_q} : {(M+1){1'b0}});

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = op_a.sign ^ op_b.sign;
                    flags_d = '0;
                    if (sp_any) begin
                        state_d          = DONE;
                        result_d         = sp_result;
                        flags_d[FLG_INV] = sp_nan;
                    end else begin
                        state_d = MULT;
                        exp_d   = EW'(op_a.exp) + EW'(op_b.exp) - BIAS_E;
                        mc_d    = M'(op_a.sig);
                        mp_d    = M'(op_b.sig);
                        acc_d   = '0;
                        cnt_d   = '0;
                        stk_d   = 1'b0;
                    end
                end
            end
            MULT: begin
                acc_d = {mac_sum, acc_q[M-1:1]};
                mp_d  = mp_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IT) state_d = NORM;
            end
            NORM: begin
                if (acc_q[2*M-1]) begin
                    acc_d = acc_q >> 1;
                    stk_d = acc_q[0];
                    exp_d = exp_q + EW'(1);
                end
                state_d = RND;
            end
            RND: begin
                result_d         = rnd_result;
                flags_d          = '0;
                flags_d[FLG_OVF] = rnd_ovf;
                flags_d[FLG_UNF] = rnd_unf;
                flags_d[FLG_INX] = rnd_inx;
                state_d          = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mc_q     <= '0;
            mp_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            stk_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mc_q     <= mc_d;
            mp_q     <= mp_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            stk_q    <= stk_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: integer-arithmetic reference model, directed and random operands.
// Expectations follow FPMUL_RNE_EN the same way the design does.
module tb_fp_mul_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_mul_seq_if #(.EXP_W(5), .MAN_W(10)) bus();
    fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc_cyc;
    } sb_item_t;

    sb_item_t sbq[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    bit  rand_rdy  = 1'b0;
    bit  force_rdy = 1'b1;
    bit  seen      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: exact integer product of the significands, then divide-and-round.
    function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic [3:0] f, output int lat);
        int ea, eb, fa, fb, sh, e;
        bit s, a_z, b_z, a_inf, b_inf, a_nan, b_nan, inx;
        longint p, q, rem, half;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        s  = a[15] ^ b[15];
        a_z = (ea == 0); b_z = (eb == 0);
        a_inf = (ea == 31) && (fa == 0); b_inf = (eb == 31) && (fb == 0);
        a_nan = (ea == 31) && (fa != 0); b_nan = (eb == 31) && (fb != 0);
        f = 4'b0000; lat = 1;
        if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) begin
            r = 16'h7E00; f = 4'b1000;
        end else if (a_inf || b_inf) begin
            r = {s, 15'h7C00};
        end else if (a_z || b_z) begin
            r = {s, 15'h0000};
        end else begin
            lat  = 14;
            p    = longint'(1024 + fa) * longint'(1024 + fb);
            sh   = (p >= (64'd1 << 21)) ? 11 : 10;
            e    = ea + eb - 15 + (sh - 10);
            q    = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            inx  = (rem != 0);
`ifdef FPMUL_RNE_EN
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            if (q == 2048) begin q = 1024; e = e + 1; end
`endif
            if (e >= 31) begin
                f = 4'b0101;
`ifdef FPMUL_RNE_EN
                r = {s, 15'h7C00};
`else
                r = {s, 15'h7BFF};
`endif
            end else if (e <= 0) begin
                f = 4'b0011; r = {s, 15'h0000};
            end else begin
                f = {3'b000, inx};
                r = {s, 5'(e), 10'(q)};
            end
        end
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit track,
                         input logic [15:0] xr, input logic [3:0] xf, input int xl);
        sb_item_t it;
        int w = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = a; bus.b = b;
        while (!bus.in_ready && w < 200) begin @(negedge clk); w++; end
        if (!bus.in_ready) begin
            chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        end else if (track) begin
            it.a = a; it.b = b; it.res = xr; it.flg = xf; it.lat = xl; it.acc_cyc = cyc;
            sbq.push_back(it);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run_ref(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r; logic [3:0] f; int l;
        ref_mul(a, b, r, f, l);
        issue(a, b, 1'b1, r, f, l);
    endtask

    function automatic logic [15:0] rand_op();
        logic [4:0] e; logic [9:0] fr; int k;
        k  = int'($urandom_range(0, 15));
        fr = 10'($urandom);
        case (k)
            0:       e = 5'd0;
            1:       begin e = 5'd31; fr = 10'd0; end
            2:       begin e = 5'd31; fr = fr | 10'd1; end
            3:       e = 5'($urandom_range(27, 30));
            4:       e = 5'($urandom_range(1, 4));
            default: e = 5'($urandom_range(8, 22));
        endcase
        return {1'($urandom_range(0, 1)), e, fr};
    endfunction

    // Monitor: first-valid latency, then result/flags on the handshake cycle.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - sbq[0].acc_cyc), 32'(sbq[0].lat));
                    seen = 1'b1;
                end
                if (bus.out_ready) begin
                    chk($sformatf("result %h*%h", sbq[0].a, sbq[0].b), 32'(bus.result), 32'(sbq[0].res));
                    chk($sformatf("flags %h*%h", sbq[0].a, sbq[0].b), 32'(bus.flags), 32'(sbq[0].flg));
                    void'(sbq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_result",    32'(bus.result),    32'd0);
        chk("reset_flags",     32'(bus.flags),     32'd0);

        issue(16'h3C00, 16'h4000, 1'b1, 16'h4000, 4'b0000, 14);
        issue(16'h3E00, 16'h3E00, 1'b1, 16'h4080, 4'b0000, 14);
        issue(16'hC000, 16'h3C00, 1'b1, 16'hC000, 4'b0000, 14);
`ifdef FPMUL_RNE_EN
        issue(16'h3C01, 16'h3E00, 1'b1, 16'h3E02, 4'b0001, 14);
        issue(16'h7BFF, 16'h4000, 1'b1, 16'h7C00, 4'b0101, 14);
`else
        issue(16'h3C01, 16'h3E00, 1'b1, 16'h3E01, 4'b0001, 14);
        issue(16'h7BFF, 16'h4000, 1'b1, 16'h7BFF, 4'b0101, 14);
`endif
        issue(16'h7C00, 16'h0000, 1'b1, 16'h7E00, 4'b1000, 1);
        issue(16'h0400, 16'h0400, 1'b1, 16'h0000, 4'b0011, 14);

        // Backpressure: DONE held for 5 cycles with out_ready low.
        w = 0;
        while (sbq.size() != 0 && w < 100) begin @(negedge clk); w++; end
        force_rdy = 1'b0;
        @(posedge clk);
        issue(16'h3C00, 16'h4000, 1'b1, 16'h4000, 4'b0000, 14);
        w = 0;
        while (!bus.out_valid && w < 50) begin @(negedge clk); w++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp_result",   32'(bus.result),   32'h4000);
            chk("bp_flags",    32'(bus.flags),    32'h0);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        force_rdy = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_hs",   32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("bp_in_ready_next", 32'(bus.in_ready), 32'd1);

        // Reset during MULT discards the operation.
        issue(16'h3C00, 16'h4000, 1'b0, 16'h0, 4'h0, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_result",    32'(bus.result),    32'd0);
        chk("mid_rst_flags",     32'(bus.flags),     32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        issue(16'h3C00, 16'h3C00, 1'b1, 16'h3C00, 4'b0000, 14);

        rand_rdy = 1'b1;
        for (int i = 0; i < 250; i++) run_ref(rand_op(), rand_op());

        w = 0;
        while (sbq.size() != 0 && w < 3000) begin @(negedge clk); w++; end
        chk("drain_queue", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
